// File: rtl/fwd_mux_pipe_if.sv
// Operand-forwarding bus between the ID stage and the forwarding selector.
// Carries the register-file read, the in-flight writers and the ID/EX results.
interface fwd_mux_pipe_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NSRC   = 3,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned SEL_W = $clog2(NSRC + 1);

  logic [ADDR_W-1:0]      src_addr;
  logic [WIDTH-1:0]       reg_data;
  logic [NSRC-1:0]        fwd_we;
  logic [NSRC*ADDR_W-1:0] fwd_addr;
  logic [NSRC*WIDTH-1:0]  fwd_data;
  logic [NSRC-1:0]        fwd_rdy;
  logic                   en;
  logic                   flush;
  logic                   stall;
  logic [WIDTH-1:0]       out_data;
  logic [SEL_W-1:0]       out_sel;
  logic                   out_valid;
  logic [CNT_W-1:0]       stall_cnt;

  modport master (
    output src_addr, reg_data, fwd_we, fwd_addr, fwd_data, fwd_rdy, en, flush,
    input  stall, out_data, out_sel, out_valid, stall_cnt
  );

  modport slave (
    input  src_addr, reg_data, fwd_we, fwd_addr, fwd_data, fwd_rdy, en, flush,
    output stall, out_data, out_sel, out_valid, stall_cnt
  );
endinterface

// File: rtl/fwd_mux_pipe.sv
// Priority operand-forwarding selector feeding the ID/EX register, with
// load-use stall detection and a saturating stall-cycle counter.
module fwd_mux_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NSRC       = 3,
  parameter int unsigned ZERO_GUARD = 1,
  parameter int unsigned CNT_W      = 16
) (
  input logic          clk,
  input logic          reset,
  fwd_mux_pipe_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NSRC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NSRC-1:0]  match;
  logic             found;
  logic [SEL_W-1:0] sel_code;
  logic [WIDTH-1:0] sel_data;
  logic             sel_rdy;
  logic             stall_c;
  logic             zero_blk;

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Youngest matching writer wins; register file when nobody matches.
  always_comb begin
    match    = '0;
    found    = 1'b0;
    sel_code = '0;
    sel_data = bus.reg_data;
    sel_rdy  = 1'b1;
    zero_blk = (ZERO_GUARD != 0) && (bus.src_addr == '0);
    for (int i = 0; i < int'(NSRC); i++) begin
      match[i] = bus.fwd_we[i] && !zero_blk &&
                 (bus.fwd_addr[i*int'(ADDR_W) +: ADDR_W] == bus.src_addr);
      if (match[i] && !found) begin
        found    = 1'b1;
        sel_code = SEL_W'(i + 1);
        sel_data = bus.fwd_data[i*int'(WIDTH) +: WIDTH];
        sel_rdy  = bus.fwd_rdy[i];
      end
    end
    stall_c = found && !sel_rdy;
  end

  // ID/EX register next state: flush, then hold, then bubble, then load.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.flush) begin
      out_data_d  = '0;
      out_sel_d   = '0;
      out_valid_d = 1'b0;
    end else if (bus.en) begin
      if (stall_c) begin
        out_valid_d = 1'b0;
      end else begin
        out_data_d  = sel_data;
        out_sel_d   = sel_code;
        out_valid_d = 1'b1;
      end
    end
    if (bus.en && stall_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fwd_mux_pipe.sv
// Directed bench for fwd_mux_pipe: default build, a CNT_W=2 build sharing
// the same stimulus, and an NSRC=1 build.
module tb_fwd_mux_pipe;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fwd_mux_pipe_if ifc ();
  fwd_mux_pipe_if #(.CNT_W(2)) ifc2 ();
  fwd_mux_pipe_if #(.NSRC(1)) ifc1 ();

  fwd_mux_pipe dut (.clk(clk), .reset(reset), .bus(ifc.slave));
  fwd_mux_pipe #(.CNT_W(2)) dut_sat (.clk(clk), .reset(reset), .bus(ifc2.slave));
  fwd_mux_pipe #(.NSRC(1)) dut_one (.clk(clk), .reset(reset), .bus(ifc1.slave));

  assign ifc2.src_addr = ifc.src_addr;
  assign ifc2.reg_data = ifc.reg_data;
  assign ifc2.fwd_we   = ifc.fwd_we;
  assign ifc2.fwd_addr = ifc.fwd_addr;
  assign ifc2.fwd_data = ifc.fwd_data;
  assign ifc2.fwd_rdy  = ifc.fwd_rdy;
  assign ifc2.en       = ifc.en;
  assign ifc2.flush    = ifc.flush;

  typedef struct {
    logic        rst;
    logic [4:0]  sa;
    logic [31:0] rd;
    logic [2:0]  we;
    logic [14:0] fa;
    logic [95:0] fd;
    logic [2:0]  rdy;
    logic        en;
    logic        fl;
    logic        e_stall;
    logic [31:0] e_data;
    logic [1:0]  e_sel;
    logic        e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic r, logic [4:0] sa, logic [31:0] rd, logic [2:0] we,
                              logic [14:0] fa, logic [95:0] fd, logic [2:0] rdy,
                              logic en, logic fl, logic es, logic [31:0] ed,
                              logic [1:0] esel, logic ev, logic [15:0] ec);
    vec_t v;
    v.rst = r; v.sa = sa; v.rd = rd; v.we = we; v.fa = fa; v.fd = fd; v.rdy = rdy;
    v.en = en; v.fl = fl; v.e_stall = es; v.e_data = ed; v.e_sel = esel;
    v.e_valid = ev; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    reset = 1'b1;
    ifc.src_addr = '0; ifc.reg_data = '0; ifc.fwd_we = '0; ifc.fwd_addr = '0;
    ifc.fwd_data = '0; ifc.fwd_rdy = '0; ifc.en = 1'b0; ifc.flush = 1'b0;
    ifc1.src_addr = '0; ifc1.reg_data = '0; ifc1.fwd_we = '0; ifc1.fwd_addr = '0;
    ifc1.fwd_data = '0; ifc1.fwd_rdy = '0; ifc1.en = 1'b0; ifc1.flush = 1'b0;

    //              rst sa     rd          we      fa (a2,a1,a0)        fd (d2,d1,d0)                   rdy     en fl  stl data          sel v  cnt
    vecs[0]  = mk(1, 5'd8, 32'h0,      3'b111, {5'd8,5'd8,5'd8}, {32'h3,32'h2,32'h1},            3'b000, 1, 0,  1, 32'h0,        0, 0, 0);
    vecs[1]  = mk(1, 5'd3, 32'h5a5a,   3'b001, {5'd0,5'd0,5'd3}, {32'h0,32'h0,32'h77},           3'b001, 1, 0,  0, 32'h0,        0, 0, 0);
    vecs[2]  = mk(0, 5'd8, 32'h11,     3'b000, {5'd8,5'd8,5'd8}, {32'h0,32'h0,32'h0},            3'b111, 1, 0,  0, 32'h11,       0, 1, 0);
    vecs[3]  = mk(0, 5'd8, 32'h55,     3'b110, {5'd8,5'd8,5'd0}, {32'hBB,32'hAA,32'h0},          3'b111, 1, 0,  0, 32'hAA,       2, 1, 0);
    vecs[4]  = mk(0, 5'd8, 32'h55,     3'b100, {5'd8,5'd8,5'd0}, {32'hBB,32'hAA,32'h0},          3'b111, 1, 0,  0, 32'hBB,       3, 1, 0);
    vecs[5]  = mk(0, 5'd0, 32'h0,      3'b001, {5'd0,5'd0,5'd0}, {32'h0,32'h0,32'hFF},           3'b001, 1, 0,  0, 32'h0,        0, 1, 0);
    vecs[6]  = mk(0, 5'd8, 32'h77,     3'b000, {5'd0,5'd0,5'd0}, {32'h0,32'h0,32'h0},            3'b000, 1, 0,  0, 32'h77,       0, 1, 0);
    vecs[7]  = mk(0, 5'd8, 32'h77,     3'b001, {5'd0,5'd0,5'd8}, {32'h0,32'h0,32'h99},           3'b000, 0, 0,  1, 32'h77,       0, 1, 0);
    vecs[8]  = mk(0, 5'd8, 32'h66,     3'b000, {5'd0,5'd0,5'd0}, {32'h0,32'h0,32'h0},            3'b000, 0, 0,  0, 32'h77,       0, 1, 0);
    vecs[9]  = mk(0, 5'd9, 32'h1,      3'b001, {5'd0,5'd0,5'd9}, {32'h0,32'h0,32'h1234},         3'b000, 1, 0,  1, 32'h77,       0, 0, 1);
    vecs[10] = mk(0, 5'd9, 32'h1,      3'b001, {5'd0,5'd0,5'd9}, {32'h0,32'h0,32'h1234},         3'b000, 1, 0,  1, 32'h77,       0, 0, 2);
    vecs[11] = mk(0, 5'd9, 32'h1,      3'b001, {5'd0,5'd0,5'd9}, {32'h0,32'h0,32'h1234},         3'b001, 1, 0,  0, 32'h1234,     1, 1, 2);
    vecs[12] = mk(0, 5'd4, 32'h2,      3'b101, {5'd4,5'd0,5'd4}, {32'hC2,32'h0,32'hC0},          3'b100, 1, 0,  1, 32'h1234,     1, 0, 3);
    vecs[13] = mk(0, 5'd4, 32'h2,      3'b001, {5'd0,5'd0,5'd4}, {32'h0,32'h0,32'hDD},           3'b001, 1, 1,  0, 32'h0,        0, 0, 3);
    vecs[14] = mk(0, 5'd4, 32'h2,      3'b001, {5'd0,5'd0,5'd4}, {32'h0,32'h0,32'hDD},           3'b000, 1, 1,  1, 32'h0,        0, 0, 4);
    vecs[15] = mk(0, 5'd4, 32'h2,      3'b001, {5'd0,5'd0,5'd4}, {32'h0,32'h0,32'hDD},           3'b001, 1, 0,  0, 32'hDD,       1, 1, 4);
    vecs[16] = mk(1, 5'd4, 32'h2,      3'b001, {5'd0,5'd0,5'd4}, {32'h0,32'h0,32'hDD},           3'b000, 1, 0,  1, 32'h0,        0, 0, 0);
    vecs[17] = mk(0, 5'd4, 32'h2,      3'b001, {5'd0,5'd0,5'd4}, {32'h0,32'h0,32'hDD},           3'b000, 1, 0,  1, 32'h0,        0, 0, 1);

    for (int k = 0; k < 18; k++) begin
      logic [15:0] sat_exp;
      reset        = vecs[k].rst;
      ifc.src_addr = vecs[k].sa;
      ifc.reg_data = vecs[k].rd;
      ifc.fwd_we   = vecs[k].we;
      ifc.fwd_addr = vecs[k].fa;
      ifc.fwd_data = vecs[k].fd;
      ifc.fwd_rdy  = vecs[k].rdy;
      ifc.en       = vecs[k].en;
      ifc.flush    = vecs[k].fl;
      #1;
      check($sformatf("v%0d stall", k), 128'(ifc.stall), 128'(vecs[k].e_stall));
      @(posedge clk);
      #1;
      sat_exp = (vecs[k].e_cnt > 16'd3) ? 16'd3 : vecs[k].e_cnt;
      check($sformatf("v%0d out_data", k), 128'(ifc.out_data), 128'(vecs[k].e_data));
      check($sformatf("v%0d out_sel", k), 128'(ifc.out_sel), 128'(vecs[k].e_sel));
      check($sformatf("v%0d out_valid", k), 128'(ifc.out_valid), 128'(vecs[k].e_valid));
      check($sformatf("v%0d stall_cnt", k), 128'(ifc.stall_cnt), 128'(vecs[k].e_cnt));
      check($sformatf("v%0d sat_cnt", k), 128'(ifc2.stall_cnt), 128'(sat_exp));
    end

    // Five further stalled cycles: wide counter keeps counting, 2-bit one pins at 3.
    for (int k = 0; k < 5; k++) @(posedge clk);
    #1;
    check("long stall cnt", 128'(ifc.stall_cnt), 128'(6));
    check("long stall sat", 128'(ifc2.stall_cnt), 128'(3));
    check("long stall valid", 128'(ifc.out_valid), 128'(0));

    // Single-source build.
    ifc.en = 1'b0;
    ifc1.src_addr = 5'd5; ifc1.reg_data = 32'h300; ifc1.fwd_we = 1'b1;
    ifc1.fwd_addr = 5'd5; ifc1.fwd_data = 32'h42; ifc1.fwd_rdy = 1'b1; ifc1.en = 1'b1;
    #1;
    check("n1 stall rdy", 128'(ifc1.stall), 128'(0));
    @(posedge clk); #1;
    check("n1 data", 128'(ifc1.out_data), 128'(32'h42));
    check("n1 sel", 128'(ifc1.out_sel), 128'(1));
    check("n1 valid", 128'(ifc1.out_valid), 128'(1));
    ifc1.fwd_rdy = 1'b0;
    #1;
    check("n1 stall", 128'(ifc1.stall), 128'(1));
    @(posedge clk); #1;
    check("n1 bubble valid", 128'(ifc1.out_valid), 128'(0));
    check("n1 bubble data", 128'(ifc1.out_data), 128'(32'h42));
    check("n1 cnt", 128'(ifc1.stall_cnt), 128'(1));
    ifc1.src_addr = 5'd6;
    #1;
    check("n1 nomatch stall", 128'(ifc1.stall), 128'(0));
    @(posedge clk); #1;
    check("n1 regfile data", 128'(ifc1.out_data), 128'(32'h300));
    check("n1 regfile sel", 128'(ifc1.out_sel), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fwd_mux_pipe.md
Name: fwd_mux_pipe

Overview:
- Parametrised operand-forwarding selector with a registered output, for the pipelined MIPS datapath.
- Replaces the fixed 2-/3-way select muxes on the ID/EX operand path.
- Compares a source register address against NSRC in-flight writers. It picks the youngest matching writer, or the register-file value if none match, and latches the result into the ID/EX stage register.
- Raises a stall when the matching writer's data is not yet available (load-use), and counts stall cycles.

Parameters:
WIDTH, 32, data width in bits
ADDR_W, 5, register address width
NSRC, 3, number of forwarding sources; index 0 is the youngest stage
ZERO_GUARD, 1, when 1, address 0 never matches (MIPS $0)
CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
src_addr  input  ADDR_W  source register address being read in ID
reg_data  input  WIDTH  register-file read data for src_addr
fwd_we  input  NSRC  bit i: source i will write a register
fwd_addr  input  NSRC*ADDR_W  source i destination address, at bits [i*ADDR_W +: ADDR_W]
fwd_data  input  NSRC*WIDTH  source i result, at bits [i*WIDTH +: WIDTH]
fwd_rdy  input  NSRC  bit i: fwd_data of source i is valid this cycle
en  input  1  pipeline advance enable for the ID/EX register
flush  input  1  squash the ID/EX register (branch/exception)
stall  output  1  combinational; the selected source is not ready
out_data  output  WIDTH  registered operand
out_sel  output  clog2(NSRC+1)  registered select code: 0 = register file, i+1 = source i
out_valid  output  1  registered; 0 marks a bubble
stall_cnt  output  CNT_W  saturating count of cycles in which en=1 and stall=1

Behaviour:
- Match: match[i] = fwd_we[i] && (fwd_addr_i == src_addr) && !(ZERO_GUARD && src_addr == 0).
- Selection: the lowest index with match[i]=1 wins. If no source matches, select reg_data with code 0.
- Selection is purely combinational. Out-of-range or duplicate matches resolve by priority only.
- stall = selected source exists && !fwd_rdy[selected]. Register-file selection never stalls. stall does not depend on en, flush or reset.
- Reset (synchronous, highest priority): out_data=0, out_sel=0, out_valid=0, stall_cnt=0.
- Register update priority, evaluated each rising edge after reset:
  - flush=1: out_data=0, out_sel=0, out_valid=0, regardless of en.
  - else en=0: all registered outputs hold.
  - else stall=1: out_valid=0 (bubble inserted); out_data and out_sel hold.
  - else: out_data=selected data, out_sel=selected code, out_valid=1.
- Latency: one cycle from selection to out_data. No combinational path from inputs to out_data or out_sel.
- stall_cnt increments when en=1 && stall=1, and is independent of flush.
- stall_cnt saturates at 2^CNT_W-1; no wrap-around. It is cleared only by reset.
- Reset asserted mid-stall: reset wins. The next cycle re-evaluates stall purely from the inputs.
- NSRC=1 must be supported. out_sel width is then 1.

Test Plan:
1. Reset held 2 cycles, inputs random -> out_data=0, out_sel=0, out_valid=0, stall_cnt=0. stall still follows inputs.
2. src_addr=8, reg_data=0x11, all fwd_we=0, en=1 -> next cycle out_data=0x11, out_sel=0, out_valid=1.
3. src_addr=8; source 1 (addr 8, data 0xAA, rdy) and source 2 (addr 8, data 0xBB, rdy) both writing -> out_data=0xAA, out_sel=2. Dropping source 1's fwd_we -> out_data=0xBB, out_sel=3.
4. src_addr=0, source 0 writes addr 0 data 0xFF, reg_data=0, ZERO_GUARD=1 -> out_data=0, out_sel=0, stall=0.
5. Load-use: source 0 matches with fwd_rdy[0]=0 for 2 cycles, then 1, en=1 throughout:
   - stall=1 for 2 cycles, with out_valid=0 and out_data holding.
   - Third edge: out_data=source 0 data, out_valid=1.
   - stall_cnt=2.
6. flush=1 together with en=1 and a valid match -> out_valid=0, out_data=0. With CNT_W=2 and 5 stalled cycles -> stall_cnt=3 (saturated).
